// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl
// ----------------
// Stall/flush sequencer for the 5-stage miniRV pipeline. It decides, every
// cycle, which pipeline registers hold and which take a bubble, based on:
//   * load-use hazards (EX load whose rd feeds the ID instruction),
//   * taken branches/jumps resolved in EX,
//   * wait-stated MEM bus accesses, which freeze the whole pipe until the
//     ack arrives or the access times out.
// It also keeps saturating counts of stall cycles and branch-flush cycles.
//
// Ports
//   cpu_clk, cpu_rst_n           clock (rising edge), async active-low reset
//   id_rs1/_re, id_rs2/_re       ID-stage source indices and read enables
//   ex_rd, ex_is_load            EX-stage destination and load flag
//   ex_br_taken                  branch/jump resolved taken in EX
//   mem_req, mem_ack             MEM-stage bus request / completion
//   pc_hold, if_id_nop,
//   if_id_flush, id_ex_hold,
//   id_ex_flush, ex_mem_hold,
//   mem_wb_flush                 pipeline controls (combinational, same cycle)
//   bus_err                      one-cycle pulse when an access times out
//   stall_cnt, flush_cnt         saturating performance counters
//
// Parameters
//   CNT_W    width of the performance counters
//   TIMEOUT  frozen cycles allowed per access before bus_err (2..255)

module pipe_hazard_ctrl #(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 16
) (
    input  logic             cpu_clk,
    input  logic             cpu_rst_n,
    input  logic [4:0]       id_rs1,
    input  logic             id_rs1_re,
    input  logic [4:0]       id_rs2,
    input  logic             id_rs2_re,
    input  logic [4:0]       ex_rd,
    input  logic             ex_is_load,
    input  logic             ex_br_taken,
    input  logic             mem_req,
    input  logic             mem_ack,
    output logic             pc_hold,
    output logic             if_id_nop,
    output logic             if_id_flush,
    output logic             id_ex_hold,
    output logic             id_ex_flush,
    output logic             ex_mem_hold,
    output logic             mem_wb_flush,
    output logic             bus_err,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    // wait_cnt value on which a still-unacknowledged access gives up.
    // The first frozen cycle happens in RUN, so WAIT contributes
    // TIMEOUT-1 frozen cycles (wait_cnt 0..TIMEOUT-2) before this one.
    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

    state_t           state_q, state_d;
    logic [7:0]       wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic lu_hit;
    logic in_wait;
    logic wait_last;
    logic frz;
    logic tmo;
    logic win_br;
    logic win_lu;

    // ------------------------------------------------------------------
    // Hazard detection and arbitration
    // ------------------------------------------------------------------
    always_comb begin
        lu_hit    = ex_is_load && (ex_rd != 5'd0) &&
                    ((id_rs1_re && (id_rs1 == ex_rd)) ||
                     (id_rs2_re && (id_rs2 == ex_rd)));
        in_wait   = (state_q == ST_WAIT);
        wait_last = (wait_cnt_q == WAIT_LAST);

        // An ack in the same cycle as the request (RUN) or in any WAIT
        // cycle, including the last one, ends the access without a freeze.
        frz = (!in_wait && mem_req && !mem_ack) ||
              ( in_wait && !mem_ack && !wait_last);
        tmo = in_wait && !mem_ack && wait_last;

        // The timeout cycle is an action of its own: it drops the holds and
        // only scrubs MEM/WB, so branch and load-use are suppressed there too.
        win_br = !frz && !tmo && ex_br_taken;
        win_lu = !frz && !tmo && !ex_br_taken && lu_hit;
    end

    // ------------------------------------------------------------------
    // Pipeline controls (combinational; forced low while in reset)
    // ------------------------------------------------------------------
    always_comb begin
        pc_hold      = 1'b0;
        if_id_nop    = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_hold   = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_hold  = 1'b0;
        mem_wb_flush = 1'b0;
        bus_err      = 1'b0;
        if (cpu_rst_n) begin
            if (frz) begin
                pc_hold      = 1'b1;
                if_id_nop    = 1'b1;
                id_ex_hold   = 1'b1;
                ex_mem_hold  = 1'b1;
                mem_wb_flush = 1'b1;
            end else if (tmo) begin
                mem_wb_flush = 1'b1;
                bus_err      = 1'b1;
            end else if (win_br) begin
                // PC is left free so it can load the branch target.
                if_id_flush = 1'b1;
                id_ex_flush = 1'b1;
            end else if (win_lu) begin
                // One bubble: the bubble in ID/EX clears ex_is_load next
                // cycle, so the hazard does not retrigger by itself.
                pc_hold     = 1'b1;
                if_id_nop   = 1'b1;
                id_ex_flush = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Bus-access FSM and counters: next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        wait_cnt_d  = wait_cnt_q;
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;

        case (state_q)
            ST_RUN: begin
                if (mem_req && !mem_ack) begin
                    state_d    = ST_WAIT;
                    wait_cnt_d = 8'd0;
                end
            end
            ST_WAIT: begin
                // mem_req is not looked at here: the access in flight
                // is the one being waited on.
                if (mem_ack || wait_last) begin
                    state_d = ST_RUN;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        if ((frz || win_lu) && (stall_cnt_q != {CNT_W{1'b1}})) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (win_br && (flush_cnt_q != {CNT_W{1'b1}})) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q     <= ST_RUN;
            wait_cnt_q  <= 8'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
    assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Testbench for pipe_hazard_ctrl: table vectors, directed multi-cycle
// sequences (freeze/ack, timeout, saturation, reset during an access) and
// randomized traffic checked against a behavioural model.

module tb_pipe_hazard_ctrl;

    localparam int CW   = 4;
    localparam int TO   = 4;
    localparam int SMAX = (1 << CW) - 1;

    // Expected control vectors, packed as
    // {pc_hold, if_id_nop, if_id_flush, id_ex_hold, id_ex_flush,
    //  ex_mem_hold, mem_wb_flush, bus_err}
    localparam logic [7:0] C_NONE = 8'b0000_0000;
    localparam logic [7:0] C_LU   = 8'b1100_1000;
    localparam logic [7:0] C_BR   = 8'b0010_1000;
    localparam logic [7:0] C_FRZ  = 8'b1101_0110;
    localparam logic [7:0] C_TMO  = 8'b0000_0011;

    logic          cpu_clk = 1'b0;
    logic          cpu_rst_n = 1'b1;
    logic [4:0]    id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
    logic          id_rs1_re = 1'b0, id_rs2_re = 1'b0;
    logic          ex_is_load = 1'b0, ex_br_taken = 1'b0;
    logic          mem_req = 1'b0, mem_ack = 1'b0;
    logic          pc_hold, if_id_nop, if_id_flush, id_ex_hold, id_ex_flush;
    logic          ex_mem_hold, mem_wb_flush, bus_err;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic [7:0]    ctl_vec;

    int total = 0;
    int bad   = 0;

    // Behavioural model state: whether an access is outstanding, how many
    // cycles it has frozen the pipe so far, and the two counters.
    bit m_wait;
    int m_frozen;
    int m_stall;
    int m_flush;

    pipe_hazard_ctrl #(.CNT_W(CW), .TIMEOUT(TO)) dut (
        .cpu_clk      (cpu_clk),
        .cpu_rst_n    (cpu_rst_n),
        .id_rs1       (id_rs1),
        .id_rs1_re    (id_rs1_re),
        .id_rs2       (id_rs2),
        .id_rs2_re    (id_rs2_re),
        .ex_rd        (ex_rd),
        .ex_is_load   (ex_is_load),
        .ex_br_taken  (ex_br_taken),
        .mem_req      (mem_req),
        .mem_ack      (mem_ack),
        .pc_hold      (pc_hold),
        .if_id_nop    (if_id_nop),
        .if_id_flush  (if_id_flush),
        .id_ex_hold   (id_ex_hold),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_hold  (ex_mem_hold),
        .mem_wb_flush (mem_wb_flush),
        .bus_err      (bus_err),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 cpu_clk = ~cpu_clk;

    assign ctl_vec = {pc_hold, if_id_nop, if_id_flush, id_ex_hold,
                      id_ex_flush, ex_mem_hold, mem_wb_flush, bus_err};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end else begin
            $display("ok   %s: %0h", nm, act);
        end
    endtask

    task automatic set_in(input logic [4:0] rs1, input logic re1,
                          input logic [4:0] rs2, input logic re2,
                          input logic [4:0] rd, input logic ld, input logic br,
                          input logic req, input logic ack);
        id_rs1 = rs1; id_rs1_re = re1; id_rs2 = rs2; id_rs2_re = re2;
        ex_rd = rd; ex_is_load = ld; ex_br_taken = br;
        mem_req = req; mem_ack = ack;
    endtask

    task automatic model_reset();
        m_wait = 0; m_frozen = 0; m_stall = 0; m_flush = 0;
    endtask

    // One cycle of the model: expected controls for the current inputs,
    // and the bookkeeping that happens at the following clock edge.
    task automatic model_step(output logic [7:0] exp);
        bit lu, freeze, tmo;
        lu = ex_is_load && (ex_rd != 0) &&
             ((id_rs1_re && id_rs1 == ex_rd) || (id_rs2_re && id_rs2 == ex_rd));
        freeze = 0;
        tmo    = 0;
        if (!m_wait) begin
            freeze = mem_req && !mem_ack;
        end else if (!mem_ack) begin
            // An access may freeze TO cycles in total; the next unacked
            // cycle is the timeout.
            if (m_frozen == TO) tmo = 1;
            else                freeze = 1;
        end

        if (freeze)           exp = C_FRZ;
        else if (tmo)         exp = C_TMO;
        else if (ex_br_taken) exp = C_BR;
        else if (lu)          exp = C_LU;
        else                  exp = C_NONE;

        if (exp == C_FRZ || exp == C_LU) m_stall = (m_stall < SMAX) ? m_stall + 1 : SMAX;
        if (exp == C_BR)                 m_flush = (m_flush < SMAX) ? m_flush + 1 : SMAX;

        if (freeze) begin
            m_wait   = 1;
            m_frozen = m_frozen + 1;
        end else begin
            m_wait   = 0;
            m_frozen = 0;
        end
    endtask

    // Called with inputs already driven just after a rising edge. Checks the
    // combinational controls mid-cycle (against ref_exp if use_ref, else the
    // model), then the counters just after the next rising edge.
    task automatic run_cycle(input string nm, input bit use_ref, input logic [7:0] ref_exp);
        logic [7:0] mexp;
        #1;
        model_step(mexp);
        chk({nm, "_ctl"}, {24'b0, ctl_vec}, {24'b0, use_ref ? ref_exp : mexp});
        @(posedge cpu_clk);
        #1;
        chk({nm, "_stall"}, {28'b0, stall_cnt}, 32'(m_stall));
        chk({nm, "_flush"}, {28'b0, flush_cnt}, 32'(m_flush));
    endtask

    task automatic do_reset();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        #2;
        cpu_rst_n = 1'b0;
        #1;
        chk("rst_ctl", {24'b0, ctl_vec}, 32'h0);
        chk("rst_stall", {28'b0, stall_cnt}, 32'h0);
        chk("rst_flush", {28'b0, flush_cnt}, 32'h0);
        model_reset();
        @(posedge cpu_clk);
        #1;
        cpu_rst_n = 1'b1;
    endtask

    typedef struct {
        logic [4:0] rs1;
        logic       re1;
        logic [4:0] rs2;
        logic       re2;
        logic [4:0] rd;
        logic       ld;
        logic       br;
        logic [7:0] exp;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int s0;
        // Single-cycle vectors from RUN with no bus activity.
        tbl[0] = '{5'd5,  1'b1, 5'd0,  1'b0, 5'd5,  1'b1, 1'b0, C_LU};   // rs1 load-use
        tbl[1] = '{5'd0,  1'b1, 5'd0,  1'b1, 5'd0,  1'b1, 1'b0, C_NONE}; // rd = x0
        tbl[2] = '{5'd5,  1'b0, 5'd0,  1'b0, 5'd5,  1'b1, 1'b0, C_NONE}; // rs1 not read
        tbl[3] = '{5'd1,  1'b1, 5'd9,  1'b1, 5'd9,  1'b1, 1'b0, C_LU};   // rs2 load-use
        tbl[4] = '{5'd1,  1'b1, 5'd9,  1'b0, 5'd9,  1'b1, 1'b0, C_NONE}; // rs2 not read
        tbl[5] = '{5'd7,  1'b1, 5'd7,  1'b1, 5'd7,  1'b0, 1'b0, C_NONE}; // not a load
        tbl[6] = '{5'd5,  1'b1, 5'd0,  1'b0, 5'd5,  1'b1, 1'b1, C_BR};   // branch beats lu
        tbl[7] = '{5'd2,  1'b0, 5'd3,  1'b0, 5'd0,  1'b0, 1'b1, C_BR};   // plain branch
        tbl[8] = '{5'd30, 1'b1, 5'd31, 1'b1, 5'd29, 1'b1, 1'b0, C_NONE}; // no index match
        tbl[9] = '{5'd31, 1'b1, 5'd31, 1'b1, 5'd31, 1'b1, 1'b0, C_LU};   // both match x31

        #2;
        do_reset();

        // T1: single load-use bubble, then the bubble clears the load.
        set_in(5, 1, 0, 0, 5, 1, 0, 0, 0);
        run_cycle("t1_lu", 1, C_LU);
        chk("t1_stall_is_1", {28'b0, stall_cnt}, 32'd1);
        set_in(5, 1, 0, 0, 5, 0, 0, 0, 0);
        run_cycle("t1_after", 1, C_NONE);

        for (int i = 0; i < 10; i++) begin
            set_in(tbl[i].rs1, tbl[i].re1, tbl[i].rs2, tbl[i].re2,
                   tbl[i].rd, tbl[i].ld, tbl[i].br, 0, 0);
            run_cycle($sformatf("tbl%0d", i), 1, tbl[i].exp);
        end

        // T3: branch wins over a simultaneous load-use.
        do_reset();
        set_in(5, 1, 0, 0, 5, 1, 1, 0, 0);
        run_cycle("t3_br", 1, C_BR);
        chk("t3_flush_is_1", {28'b0, flush_cnt}, 32'd1);
        chk("t3_stall_is_0", {28'b0, stall_cnt}, 32'd0);

        // T4: ack on the fourth cycle -> three frozen cycles.
        s0 = m_stall;
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < 3; i++) run_cycle($sformatf("t4_frz%0d", i), 1, C_FRZ);
        mem_ack = 1;
        run_cycle("t4_ack", 1, C_NONE);
        chk("t4_stall_plus3", {28'b0, stall_cnt}, 32'(s0 + 3));
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_cycle("t4_idle", 1, C_NONE);
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 1);
        run_cycle("t4_same_cyc_ack", 1, C_NONE);

        // T5: no ack -> TO frozen cycles, then a one-cycle bus_err.
        s0 = m_stall;
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < TO; i++) run_cycle($sformatf("t5_frz%0d", i), 1, C_FRZ);
        run_cycle("t5_timeout", 1, C_TMO);
        chk("t5_stall_plus_to", {28'b0, stall_cnt}, 32'((s0 + TO > SMAX) ? SMAX : s0 + TO));
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        run_cycle("t5_after", 1, C_NONE);

        // Ack in the last allowed cycle beats the timeout.
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        for (int i = 0; i < TO; i++) run_cycle($sformatf("t5b_frz%0d", i), 1, C_FRZ);
        mem_ack = 1;
        run_cycle("t5b_late_ack", 1, C_NONE);

        // T6: counter saturation.
        do_reset();
        set_in(5, 1, 0, 0, 5, 1, 0, 0, 0);
        for (int i = 0; i < 20; i++) run_cycle($sformatf("t6_lu%0d", i), 1, C_LU);
        chk("t6_stall_sat", {28'b0, stall_cnt}, 32'(SMAX));

        // Reset while waiting on a bus access; request still asserted.
        set_in(0, 0, 0, 0, 0, 0, 0, 1, 0);
        run_cycle("t6_frz0", 1, C_FRZ);
        run_cycle("t6_frz1", 1, C_FRZ);
        #2;
        cpu_rst_n = 1'b0;
        #1;
        chk("t6_async_ctl", {24'b0, ctl_vec}, 32'h0);
        chk("t6_async_stall", {28'b0, stall_cnt}, 32'h0);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 1);
        model_reset();
        @(posedge cpu_clk);
        #1;
        cpu_rst_n = 1'b1;
        run_cycle("t6_stale_ack", 1, C_NONE);

        // Randomized traffic against the model, with occasional resets.
        for (int i = 0; i < 1500; i++) begin
            if (i % 250 == 249) begin
                do_reset();
            end else begin
                set_in(5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 5) == 0),
                       1'($urandom_range(0, 3) == 0),
                       1'($urandom_range(0, 2) == 0));
                run_cycle("rnd", 0, C_NONE);
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
